key_typematic_ctrl: RTL and testbench

KEY_TYPEMATIC_CTRL -- requirements
Module: key_typematic_ctrl

---
 rtl/key_typematic_ctrl_pkg.sv | 28 ++
 rtl/key_typematic_ctrl_if.sv | 30 +++
 rtl/key_typematic_ctrl_fifo.sv | 70 +++++++
 rtl/key_typematic_ctrl.sv | 124 ++++++++++++
 tb/tb_key_typematic_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/key_typematic_ctrl_pkg.sv
// Shared definitions for the keyboard typematic controller: event word layout,
// FSM state encoding and the default timing constants for a 50 MHz clock.
package key_pkg;

  // Event word layout
  localparam int EV_W         = 12;
  localparam int EV_ASCII_LSB = 0;
  localparam int EV_ASCII_MSB = 7;
  localparam int EV_DIR_BIT   = 8;
  localparam int EV_CTRL_BIT  = 9;
  localparam int EV_ALT_BIT   = 10;
  localparam int EV_REP_BIT   = 11;

  // Default timing: 500 ms initial delay, 20 Hz repeat at 50 MHz
  localparam int DEF_DELAY_CYC = 25_000_000;
  localparam int DEF_RATE_CYC  = 2_500_000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } key_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_typematic_ctrl_if.sv
// Event stream from the typematic controller to its consumer.
//
// Handshake: ev_valid is high whenever the FIFO holds an event and ev_data is
// the head event. An event is transferred on every rising clock edge where
// ev_valid && ev_ready; ev_ready while ev_valid is low has no effect.
// ev_valid/ev_data do not depend combinationally on ev_ready.
interface key_typematic_ctrl_if #(
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          ev_valid;
  logic          ev_ready;
  logic [11:0]   ev_data;
  logic [CW-1:0] ev_count;

  modport master (
    output ev_valid,
    output ev_data,
    output ev_count,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_data,
    input  ev_count,
    output ev_ready
  );
endinterface

// File: rtl/key_typematic_ctrl_fifo.sv
// First-word-fall-through event FIFO with a sticky overflow flag.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module key_event_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_req_i,
  input  logic                     clr_ovf_i,
  output logic                     valid_o,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     overflow_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      count_q;
  logic             ovf_q;

  logic empty;
  logic full;
  logic do_pop;
  logic do_wr;
  logic drop;

  // A write into a full FIFO is still accepted when the head leaves the same cycle
  assign empty  = (count_q == '0);
  assign full   = (count_q == (AW+1)'(DEPTH));
  assign do_pop = pop_req_i && !empty;
  assign do_wr  = push_i && (!full || do_pop);
  assign drop   = push_i && full && !do_pop;

  // Pointer, occupancy and overflow bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + 1'b1;
      if (do_pop) rptr_q <= rptr_q + 1'b1;
      case ({do_wr, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      // A drop in the same cycle as a clear leaves the flag set
      if (drop) ovf_q <= 1'b1;
      else if (clr_ovf_i) ovf_q <= 1'b0;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q] <= wdata_i;
  end

  assign valid_o    = !empty;
  assign rdata_o    = empty ? '0 : mem_q[rptr_q];
  assign count_o    = count_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/key_typematic_ctrl.sv
// Keyboard typematic controller: turns a held scan code into one press event
// followed, after DELAY_CYC cycles, by repeat events every RATE_CYC cycles.
// Events are queued in a FWFT FIFO for the consumer.
module key_typematic_ctrl
  import key_pkg::*;
#(
  parameter int DELAY_CYC = DEF_DELAY_CYC,
  parameter int RATE_CYC  = DEF_RATE_CYC,
  parameter int DEPTH     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           cur_key,
  input  logic [7:0]           ascii_key,
  input  logic                 is_dir,
  input  logic                 ctrl,
  input  logic                 alt,
  input  logic                 rep_en,
  input  logic                 clr_ovf,
  output logic                 overflow,
  output key_state_e           dbg_state,
  key_typematic_ctrl_if.master ev_bus
);
  localparam int TMR_MAX = max_int(DELAY_CYC, RATE_CYC);
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] DELAY_LOAD = TMR_W'(DELAY_CYC - 1);
  localparam logic [TMR_W-1:0] RATE_LOAD  = TMR_W'(RATE_CYC - 1);

  key_state_e       state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [7:0]       last_key_q;

  logic             push_req;
  logic             push_rep;
  logic             push;
  logic [EV_W-1:0]  ev_word;

  // State, timer and previous-key registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      tmr_q      <= '0;
      last_key_q <= '0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      last_key_q <= cur_key;
    end
  end

  // Next-state logic: press on new key, repeat on timer expiry, idle on release.
  // With rep_en low the timer simply holds, so repeats resume where they left off.
  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    push_req = 1'b0;
    push_rep = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cur_key != 8'h00) begin
          push_req = 1'b1;
          tmr_d    = DELAY_LOAD;
          state_d  = ST_DELAY;
        end
      end
      ST_DELAY, ST_REPEAT: begin
        if (cur_key == 8'h00) begin
          tmr_d   = '0;
          state_d = ST_IDLE;
        end else if (cur_key != last_key_q) begin
          push_req = 1'b1;
          tmr_d    = DELAY_LOAD;
          state_d  = ST_DELAY;
        end else if (rep_en) begin
          if (tmr_q == '0) begin
            push_req = 1'b1;
            push_rep = 1'b1;
            tmr_d    = RATE_LOAD;
            state_d  = ST_REPEAT;
          end else begin
            tmr_d = tmr_q - 1'b1;
          end
        end
      end
      default: begin
        tmr_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Event word from the same-cycle decoder inputs
  always_comb begin
    ev_word                            = '0;
    ev_word[EV_ASCII_MSB:EV_ASCII_LSB] = ascii_key;
    ev_word[EV_DIR_BIT]                = is_dir;
    ev_word[EV_CTRL_BIT]               = ctrl;
    ev_word[EV_ALT_BIT]                = alt;
    ev_word[EV_REP_BIT]                = push_rep;
  end

  // Keys with no printable code and no direction meaning produce no event,
  // but the FSM still runs its normal timing for them.
  assign push = push_req && ((ascii_key != 8'h00) || is_dir);

  key_event_fifo #(
    .WIDTH (EV_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (push),
    .wdata_i    (ev_word),
    .pop_req_i  (ev_bus.ev_ready),
    .clr_ovf_i  (clr_ovf),
    .valid_o    (ev_bus.ev_valid),
    .rdata_o    (ev_bus.ev_data),
    .count_o    (ev_bus.ev_count),
    .overflow_o (overflow)
  );

  assign dbg_state = state_q;

endmodule

// File: tb/tb_key_typematic_ctrl.sv
// Directed bench for key_typematic_ctrl with DELAY_CYC=20, RATE_CYC=5, DEPTH=4.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_key_typematic_ctrl;
  import key_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cur_key;
  logic [7:0] ascii_key;
  logic       is_dir, ctrl, alt, rep_en, clr_ovf;
  logic       overflow;
  key_state_e dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  key_typematic_ctrl_if #(.DEPTH(4)) bus ();

  key_typematic_ctrl #(
    .DELAY_CYC (20),
    .RATE_CYC  (5),
    .DEPTH     (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cur_key   (cur_key),
    .ascii_key (ascii_key),
    .is_dir    (is_dir),
    .ctrl      (ctrl),
    .alt       (alt),
    .rep_en    (rep_en),
    .clr_ovf   (clr_ovf),
    .overflow  (overflow),
    .dbg_state (dbg_state),
    .ev_bus    (bus)
  );

  // Clock
  always #5 clk = ~clk;

  // Drivers
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic release_key();
    cur_key = 8'h00; ascii_key = 8'h00;
    is_dir = 1'b0; ctrl = 1'b0; alt = 1'b0;
    bus.ev_ready = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst = 1'b1; cur_key = 8'h00; ascii_key = 8'h00;
    is_dir = 1'b0; ctrl = 1'b0; alt = 1'b0; rep_en = 1'b1; clr_ovf = 1'b0;
    bus.ev_ready = 1'b0;
    repeat (3) step();
    n_cmp++; if (bus.ev_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", bus.ev_valid); end
    n_cmp++; if (bus.ev_count !== 3'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", bus.ev_count); end
    n_cmp++; if (bus.ev_data !== 12'h000) begin n_err++; $display("FAIL reset_data got=%h exp=000", bus.ev_data); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_IDLE); end
    rst = 1'b0;
    step();
  endtask

  // Key held 40 edges: press at 0, repeats at 20, 25, 30, 35
  task automatic test_hold();
    logic        exp_v;
    logic [11:0] exp_d;
    int          seen = 0;
    bus.ev_ready = 1'b1;
    cur_key = 8'h1C; ascii_key = 8'h61;
    for (int e = 0; e < 45; e++) begin
      step();
      exp_v = (e == 0) || (e == 20) || (e == 25) || (e == 30) || (e == 35);
      exp_d = (e == 0) ? 12'h061 : 12'h861;
      n_cmp++; if (bus.ev_valid !== exp_v) begin n_err++; $display("FAIL hold_valid e=%0d got=%b exp=%b", e, bus.ev_valid, exp_v); end
      if (exp_v) begin
        n_cmp++; if (bus.ev_data !== exp_d) begin n_err++; $display("FAIL hold_data e=%0d got=%h exp=%h", e, bus.ev_data, exp_d); end
      end
      if (bus.ev_valid === 1'b1) seen++;
      if (e == 39) begin cur_key = 8'h00; ascii_key = 8'h00; end
    end
    n_cmp++; if (seen !== 5) begin n_err++; $display("FAIL hold_total got=%0d exp=5", seen); end
    release_key();
  endtask

  // Key switch at edge 10 restarts the delay for the new key
  task automatic test_switch();
    logic        exp_v;
    logic [11:0] exp_d;
    bus.ev_ready = 1'b1;
    cur_key = 8'h1C; ascii_key = 8'h61;
    for (int e = 0; e < 36; e++) begin
      step();
      exp_v = (e == 0) || (e == 10) || (e == 30);
      exp_d = (e == 0) ? 12'h061 : ((e == 10) ? 12'h062 : 12'h862);
      n_cmp++; if (bus.ev_valid !== exp_v) begin n_err++; $display("FAIL switch_valid e=%0d got=%b exp=%b", e, bus.ev_valid, exp_v); end
      if (exp_v) begin
        n_cmp++; if (bus.ev_data !== exp_d) begin n_err++; $display("FAIL switch_data e=%0d got=%h exp=%h", e, bus.ev_data, exp_d); end
      end
      if (e == 9) begin cur_key = 8'h32; ascii_key = 8'h62; end
      if (e == 31) begin cur_key = 8'h00; ascii_key = 8'h00; end
    end
    release_key();
  endtask

  // Full FIFO: drops set overflow, clear vs drop priority, push+pop when full
  task automatic test_overflow();
    bus.ev_ready = 1'b0;
    cur_key = 8'h1C; ascii_key = 8'h61;
    for (int e = 0; e < 56; e++) begin
      clr_ovf = (e == 50) || (e == 51);
      bus.ev_ready = (e == 55);
      step();
      if (e == 30) begin
        n_cmp++; if (bus.ev_count !== 3'd4) begin n_err++; $display("FAIL ovf_count30 got=%0d exp=4", bus.ev_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_flag30 got=%b exp=0", overflow); end
      end
      if (e == 35) begin
        n_cmp++; if (bus.ev_count !== 3'd4) begin n_err++; $display("FAIL ovf_count35 got=%0d exp=4", bus.ev_count); end
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag35 got=%b exp=1", overflow); end
      end
      if (e == 50) begin
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_clr_vs_drop got=%b exp=1", overflow); end
      end
      if (e == 51) begin
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clr got=%b exp=0", overflow); end
      end
      if (e == 54) begin
        n_cmp++; if (bus.ev_data !== 12'h061) begin n_err++; $display("FAIL ovf_head got=%h exp=061", bus.ev_data); end
      end
      if (e == 55) begin
        n_cmp++; if (bus.ev_count !== 3'd4) begin n_err++; $display("FAIL full_pushpop_count got=%0d exp=4", bus.ev_count); end
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL full_pushpop_ovf got=%b exp=0", overflow); end
        n_cmp++; if (bus.ev_data !== 12'h861) begin n_err++; $display("FAIL full_pushpop_head got=%h exp=861", bus.ev_data); end
      end
    end
    clr_ovf = 1'b0; bus.ev_ready = 1'b0;
    cur_key = 8'h00; ascii_key = 8'h00;
    step();
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (bus.ev_valid !== 1'b1 || bus.ev_data !== 12'h861) begin
        n_err++; $display("FAIL drain_entry k=%0d got=%b/%h exp=1/861", k, bus.ev_valid, bus.ev_data);
      end
      bus.ev_ready = 1'b1;
      step();
      bus.ev_ready = 1'b0;
    end
    n_cmp++; if (bus.ev_valid !== 1'b0 || bus.ev_count !== 3'd0) begin
      n_err++; $display("FAIL drain_empty got=%b/%0d exp=0/0", bus.ev_valid, bus.ev_count);
    end
    release_key();
  endtask

  // rep_en low freezes the timer; raising it at edge 50 gives a repeat at 69
  task automatic test_rep_en();
    logic        exp_v;
    logic [11:0] exp_d;
    bus.ev_ready = 1'b1;
    rep_en = 1'b0;
    cur_key = 8'h1C; ascii_key = 8'h61;
    for (int e = 0; e < 76; e++) begin
      step();
      exp_v = (e == 0) || (e == 69);
      exp_d = (e == 0) ? 12'h061 : 12'h861;
      n_cmp++; if (bus.ev_valid !== exp_v) begin n_err++; $display("FAIL repen_valid e=%0d got=%b exp=%b", e, bus.ev_valid, exp_v); end
      if (exp_v) begin
        n_cmp++; if (bus.ev_data !== exp_d) begin n_err++; $display("FAIL repen_data e=%0d got=%h exp=%h", e, bus.ev_data, exp_d); end
      end
      if (e == 49) rep_en = 1'b1;
      if (e == 72) begin cur_key = 8'h00; ascii_key = 8'h00; end
    end
    release_key();
  endtask

  // Reset in REPEAT with 3 queued events, key still held afterwards
  task automatic test_reset_mid();
    bus.ev_ready = 1'b0;
    cur_key = 8'h1C; ascii_key = 8'h61;
    for (int e = 0; e < 27; e++) begin
      step();
      if (e == 25) begin
        n_cmp++; if (bus.ev_count !== 3'd3) begin n_err++; $display("FAIL rmid_count got=%0d exp=3", bus.ev_count); end
      end
      if (e == 26) begin
        n_cmp++; if (dbg_state !== ST_REPEAT) begin n_err++; $display("FAIL rmid_state got=%0d exp=%0d", dbg_state, ST_REPEAT); end
      end
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (bus.ev_valid !== 1'b0 || bus.ev_count !== 3'd0) begin
      n_err++; $display("FAIL rmid_flush got=%b/%0d exp=0/0", bus.ev_valid, bus.ev_count);
    end
    n_cmp++; if (dbg_state !== ST_IDLE) begin n_err++; $display("FAIL rmid_idle got=%0d exp=%0d", dbg_state, ST_IDLE); end
    step();
    n_cmp++; if (bus.ev_valid !== 1'b1 || bus.ev_data !== 12'h061) begin
      n_err++; $display("FAIL rmid_repress got=%b/%h exp=1/061", bus.ev_valid, bus.ev_data);
    end
    release_key();
  endtask

  // Suppressed keys keep FSM timing; modifier fields land in the right bits
  task automatic test_fields();
    bus.ev_ready = 1'b1;
    cur_key = 8'h55; ascii_key = 8'h00; is_dir = 1'b0;
    for (int e = 0; e < 25; e++) begin
      step();
      n_cmp++; if (bus.ev_valid !== 1'b0) begin n_err++; $display("FAIL suppress_valid e=%0d got=%b exp=0", e, bus.ev_valid); end
      if (e == 19) begin
        n_cmp++; if (dbg_state !== ST_DELAY) begin n_err++; $display("FAIL suppress_delay got=%0d exp=%0d", dbg_state, ST_DELAY); end
      end
      if (e == 20) begin
        n_cmp++; if (dbg_state !== ST_REPEAT) begin n_err++; $display("FAIL suppress_repeat got=%0d exp=%0d", dbg_state, ST_REPEAT); end
      end
    end
    cur_key = 8'h75; ascii_key = 8'h80; is_dir = 1'b1; ctrl = 1'b1; alt = 1'b1;
    step();
    n_cmp++; if (bus.ev_valid !== 1'b1 || bus.ev_data !== 12'h780) begin
      n_err++; $display("FAIL field_dir got=%b/%h exp=1/780", bus.ev_valid, bus.ev_data);
    end
    cur_key = 8'h76; ascii_key = 8'h41; is_dir = 1'b0; ctrl = 1'b1; alt = 1'b0;
    step();
    n_cmp++; if (bus.ev_valid !== 1'b1 || bus.ev_data !== 12'h241) begin
      n_err++; $display("FAIL field_ctrl got=%b/%h exp=1/241", bus.ev_valid, bus.ev_data);
    end
    release_key();
  endtask

  initial begin
    test_reset();
    test_hold();
    test_switch();
    test_overflow();
    test_rep_en();
    test_reset_mid();
    test_fields();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
